// File: rtl/systolic_west_feeder.sv
// systolic_west_feeder
// Feeds operand columns into the west edge of a systolic array. Lane i is
// delayed by 1+i cycles so the wavefront arrives diagonally. Cycles without
// an accepted column inject a zero with its lane-valid flag low.
// Optional feature: define FEEDER_STALL_CNT_EN to build the stall counter.
// Without it, stall_cnt is tied to zero.
module systolic_west_feeder #(
  parameter int WIDTH   = 8,
  parameter int N_LANES = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [N_LANES*WIDTH-1:0]   s_data,
  input  logic                       s_last,
  output logic [N_LANES*WIDTH-1:0]   out_west,
  output logic [N_LANES-1:0]         out_lane_valid,
  output logic                       pe_clear,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           beat_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int DW = $clog2(N_LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] beat_q,  beat_d;
  logic             hs;

  // Saturating increment shared by the beat and stall counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign s_ready  = (state_q == S_STREAM);
  assign hs       = s_valid & s_ready;
  assign pe_clear = (state_q == S_CLEAR);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign beat_cnt = beat_q;

  // Next-state, drain countdown and beat counter.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          beat_d  = '0;
        end
      end
      S_CLEAR: state_d = S_STREAM;
      S_STREAM: begin
        if (hs) begin
          beat_d = sat_inc(beat_q);
          if (s_last) begin
            state_d = S_DRAIN;
            drain_d = DW'(N_LANES - 1);
          end
        end
      end
      S_DRAIN: begin
        // N_LANES cycles: long enough for the last column to leave lane N_LANES-1.
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Stall counter: zeroed when a tile starts, counts STREAM cycles with no column offered.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start)
      stall_d = '0;
    else if (state_q == S_STREAM && !s_valid)
      stall_d = sat_inc(stall_q);
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  // Per-lane skew chains: lane i is 1+i registers deep.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic signed [WIDTH-1:0] dat_q [i+1];
    logic signed [WIDTH-1:0] dat_d [i+1];
    logic [i:0]              vld_q, vld_d;

    // Stage 0 takes the accepted element or a zero bubble; later stages shift.
    always_comb begin
      dat_d[0] = hs ? s_data[i*WIDTH +: WIDTH] : '0;
      vld_d[0] = hs;
      for (int j = 1; j <= i; j++) begin
        dat_d[j] = dat_q[j-1];
        vld_d[j] = vld_q[j-1];
      end
    end

    // Skew register chain for this lane.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) dat_q[j] <= '0;
        vld_q <= '0;
      end else begin
        for (int j = 0; j <= i; j++) dat_q[j] <= dat_d[j];
        vld_q <= vld_d;
      end
    end

    assign out_west[i*WIDTH +: WIDTH] = dat_q[i];
    assign out_lane_valid[i]          = vld_q[i];
  end

endmodule

// File: doc/systolic_west_feeder.md
SYSTOLIC_WEST_FEEDER -- requirements
Module: systolic_west_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand width per lane (Q4.4 signed, two's complement).
REQ-002 SHALL have parameter N_LANES, default 4, meaning the number of PE rows driven on the array's west edge.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the beat and stall counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a tile.
REQ-007 SHALL have port s_valid, input, 1, meaning an operand column is present.
REQ-008 SHALL have port s_ready, output, 1, meaning the feeder accepts a column this cycle.
REQ-009 SHALL have port s_data, input, N_LANES*WIDTH, one element per lane, with lane i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port s_last, input, 1, marking the final column of the tile (the K-th beat).
REQ-011 SHALL have port out_west, output, N_LANES*WIDTH, the skewed operands that drive each PE row's in_west.
REQ-012 SHALL have port out_lane_valid, output, N_LANES, a per-lane flag marking a real (non-bubble) operand.
REQ-013 SHALL have port pe_clear, output, 1, a pulse that clears the PE accumulators before a tile.
REQ-014 SHALL have port busy, output, 1, asserted whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse when the tile has fully exited lane N_LANES-1.
REQ-016 SHALL have port beat_cnt, output, CNT_W, counting the columns accepted in the current tile.
REQ-017 SHALL have port stall_cnt, output, CNT_W, counting STREAM cycles with s_valid=0 (see Configuration).

Function
REQ-018 SHALL implement the FSM states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-019 SHALL transition IDLE->CLEAR on start=1, CLEAR->STREAM after 1 cycle, STREAM->DRAIN on a handshake with s_last=1, DRAIN->DONE after exactly N_LANES cycles, and DONE->IDLE after 1 cycle.
REQ-020 SHALL drive pe_clear=1 only in CLEAR, done=1 only in DONE, and s_ready=1 only in STREAM.
REQ-021 SHALL define a handshake as s_valid&s_ready; on a handshake, lane i's element SHALL appear on out_west lane i exactly 1+i cycles later, with out_lane_valid[i]=1.
REQ-022 SHALL inject zero with lane valid=0 into lane 0 on every cycle without a handshake (bubbles, DRAIN, IDLE), so MAC contribution is 0.
REQ-023 SHALL implement the skew as a per-lane register chain of depth 1+i; lanes SHALL never reorder or drop data.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL clear beat_cnt to 0 on entering CLEAR, increment it per handshake, and saturate it at 2^CNT_W-1.
REQ-026 SHALL hold s_ready at 0 and leave data unconsumed if s_valid=1 outside STREAM.
REQ-027 SHALL, when s_last=1 on the first beat (K=1), enter DRAIN the next cycle and assert done at cycle accept+N_LANES+1.
REQ-028 SHALL, when s_last=1 arrives with s_valid=1 but s_ready=0, ignore it.

Reset
REQ-029 SHALL, while rst=1, immediately force state IDLE, all skew registers 0, out_west 0, out_lane_valid 0, s_ready/pe_clear/busy/done 0, and beat_cnt/stall_cnt 0.
REQ-030 SHALL, on reset mid-tile, discard in-flight data with no done pulse; a new start is required after reset.

Configuration
REQ-031 SHALL, with FEEDER_STALL_CNT_EN defined, clear stall_cnt on CLEAR and increment it (saturating) on each STREAM cycle with s_valid=0.
REQ-032 SHALL, without FEEDER_STALL_CNT_EN, tie stall_cnt to constant 0 and synthesize no counter logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover reset then idle: rst pulse -> all outputs 0, s_ready=0 with s_valid=1 held.
REQ-034 SHALL cover a basic tile with N_LANES=4: start, then 2 beats of lanes {0x18,0x20,0x10,0xF0}, {0x10,0x10,0x10,0x10} with s_last on beat 2 -> lane0 gets 0x18 at t+1, lane3 gets 0xF0 at t+4; done asserts once, 4 cycles after DRAIN entry; beat_cnt=2.
REQ-035 SHALL cover a bubble: s_valid low for 1 cycle between beats -> a zero with valid=0 slot appears in each lane at the skewed position; stall_cnt=1 with the macro defined, 0 without.
REQ-036 SHALL cover K=1: a single beat with s_last -> DRAIN is entered the next cycle and done appears at accept+5.
REQ-037 SHALL cover start while busy: a second start during STREAM -> no state change and pe_clear is not re-asserted.
REQ-038 SHALL cover reset mid-DRAIN: rst asserted -> out_west=0 immediately, no done, and start afterwards runs a clean tile.
